sign_mag_accum: RTL and testbench
=================================

Name: sign_mag_accum

Overview:
Sequential accumulator that consumes a stream of N-bit sign-magnitude operands and produces their running sign-magnitude total after a programmed number of terms. It sits directly downstream of the operand source and feeds the accumulated value back through a combinational sign-magnitude adder each accepted beat. The block adds saturation, a sticky overflow flag and valid/ready handshakes on both sides.

Parameters:
N, 4, operand/result width; bit N-1 = sign (1 = negative), bits N-2:0 = magnitude
MAX_TERMS, 8, largest legal num_terms
CW, $clog2(MAX_TERMS+1), width of the term counter (derived)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin a new accumulation (honoured only in IDLE)
num_terms  input  CW  number of operands to accumulate, sampled with start
in_valid  input  1  in_data holds an operand
in_ready  output  1  block accepts an operand this cycle
in_data  input  N  sign-magnitude operand
out_valid  output  1  out_sum/out_ovf are valid
out_ready  input  1  consumer takes result this cycle
out_sum  output  N  accumulated sign-magnitude result
out_ovf  output  1  sticky: any step overflowed (result saturated)
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (synchronous, active-high): state=IDLE, acc=0, cnt=0, ovf=0; in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0 from the cycle after the reset edge. Reset mid-ACCUM or mid-DONE discards all progress.
- States: IDLE, ACCUM, DONE. in_ready = (state==ACCUM); out_valid = (state==DONE); busy = (state!=IDLE).
- IDLE: start && num_terms>0 -> ACCUM, acc=+0, cnt=num_terms, ovf=0. start && num_terms==0 -> DONE, acc=+0, ovf=0. num_terms>MAX_TERMS is illegal; the bench flags it as an error.
- ACCUM: accept when in_valid && in_ready. Per accept: acc <= smadd(acc, in_data); cnt <= cnt-1. If cnt==1 on accept -> DONE next cycle. No accept -> hold all state. start is ignored.
- smadd rules: same signs -> add magnitudes, keep the sign. Different signs -> subtract the smaller magnitude from the larger and take the sign of the larger. Equal magnitudes -> +0.
- Negative zero: an in_data of sign=1, mag=0 is treated as +0. The result is never 1 followed by zeros.
- Overflow: same signs and magnitude sum > 2^(N-1)-1 -> acc saturates to sign with all magnitude bits 1 (+-7 for N=4), and ovf <= 1 (sticky for this run). Later terms add to the saturated value normally.
- DONE: out_sum=acc, out_ovf=ovf held stable while out_valid && !out_ready. On out_valid && out_ready -> IDLE. start in DONE is ignored, including when it coincides with out_ready.
- Latency: out_valid asserts the cycle after the final operand is accepted. Throughput is 1 operand/cycle. A back-to-back run costs 1 IDLE cycle between results.
- out_sum/out_ovf retain their last values in IDLE. They reset only on reset or on a new start.

Decomposition:
- Package sign_mag_pkg: parameter N default, localparam MAG_MAX = 2^(N-1)-1, typedef state_t {IDLE, ACCUM, DONE}, and helper functions sm_sign()/sm_mag().
- One sub-module: the combinational adder sign_mag_add (ports a, b, sum), instantiated with a=acc and b=in_data.
- Overflow detection, saturation and negative-zero normalisation stay in sign_mag_accum so that they do not depend on the adder's overflow encoding.

Test Plan:
1. Assert reset for 2 cycles with random inputs -> in_ready=0, out_valid=0, out_sum=0000, out_ovf=0, busy=0.
2. start, num_terms=3; feed 0011, 1100, 0110 with in_valid continuous -> out_valid the cycle after the 3rd accept; out_sum=0101 (+5), out_ovf=0.
3. num_terms=2; feed 0110, 0110 -> out_sum=0111 (+7 saturated), out_ovf=1. Repeat with 1110, 1110 -> out_sum=1111, out_ovf=1.
4. num_terms=2; feed 0100, 1100 -> out_sum=0000 (never 1000). Then num_terms=2 with 1010, 1011 -> out_sum=1101 (-5), out_ovf=0.
5. Backpressure: num_terms=3 with in_valid low 2 cycles between operands -> cnt holds, result still correct. Hold out_ready low 3 cycles in DONE, pulse start -> out_sum stable, start ignored, IDLE after out_ready=1.
6. num_terms=0 -> DONE next cycle with 0000. Separately, assert reset after 1 of 3 terms -> IDLE next cycle; a fresh run yields only the new terms' sum.

Source files
------------

// File: rtl/sign_mag_pkg.sv
// sign_mag_pkg: shared operand width, FSM state encoding and sign-magnitude field helpers
package sign_mag_pkg;

    localparam int N = 4;
    localparam logic [N-2:0] MAG_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    function automatic logic sm_sign(input logic [N-1:0] v);
        return v[N-1];
    endfunction

    function automatic logic [N-2:0] sm_mag(input logic [N-1:0] v);
        return v[N-2:0];
    endfunction

endpackage

// File: rtl/sign_mag_add.sv
// sign_mag_add: combinational sign-magnitude adder, magnitude wraps on overflow
module sign_mag_add #(
    parameter int N = sign_mag_pkg::N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    logic [N-2:0] ma, mb, m;
    logic         sa, sb, s;

    always_comb begin
        sa  = a[N-1];
        sb  = b[N-1];
        ma  = a[N-2:0];
        mb  = b[N-2:0];
        m   = sa == sb ? ma + mb : (ma >= mb ? ma - mb : mb - ma);
        s   = sa == sb ? sa : (ma >= mb ? sa : sb);
        sum = {s && m != '0, m};
    end

endmodule

// File: rtl/sign_mag_accum.sv
// sign_mag_accum: handshaked saturating sign-magnitude accumulator over a programmed term count
module sign_mag_accum
    import sign_mag_pkg::*;
#(
    parameter int N         = sign_mag_pkg::N,
    parameter int MAX_TERMS = 8,
    parameter int CW        = $clog2(MAX_TERMS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] num_terms,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic          out_ovf,
    output logic          busy
);

    state_t        state;
    logic [N-1:0]  acc, raw, nxt;
    logic [CW-1:0] cnt;
    logic          ovf, sat;

    sign_mag_add #(.N(N)) u_add (.a(acc), .b(in_data), .sum(raw));

    // overflow is judged on the full-width magnitude sum, independent of how the adder wraps
    always_comb begin
        sat = sm_sign(acc) == sm_sign(in_data)
              && {1'b0, sm_mag(acc)} + {1'b0, sm_mag(in_data)} > {1'b0, MAG_MAX};
        nxt = sat ? {sm_sign(acc), MAG_MAX} : {sm_sign(raw) && sm_mag(raw) != '0, sm_mag(raw)};
    end

    assign in_ready  = state == ACCUM;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign out_sum   = acc;
    assign out_ovf   = ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                state <= num_terms == '0 ? DONE : ACCUM;
                acc   <= '0;
                cnt   <= num_terms;
                ovf   <= 1'b0;
            end
        end else if (state == ACCUM) begin
            if (in_valid) begin
                acc <= nxt;
                ovf <= ovf | sat;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) state <= DONE;
            end
        end else if (state != DONE || out_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_sign_mag_accum.sv
// tb_sign_mag_accum: scenario tasks against an integer-arithmetic scoreboard model
module tb_sign_mag_accum;

    typedef logic [3:0] ops_t [8];
    typedef struct packed {logic [3:0] sum; logic ovf;} exp_t;

    logic       clk = 0, reset = 0, start = 0, in_valid = 0, out_ready = 0;
    logic [3:0] num_terms = 0, in_data = 0;
    logic       in_ready, out_valid, out_ovf, busy;
    logic [3:0] out_sum;
    exp_t       sb[$];
    int         n_cmp = 0, n_bad = 0;

    sign_mag_accum dut (
        .clk(clk), .reset(reset), .start(start), .num_terms(num_terms),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input ops_t ops, input int nt);
        int v = 0, x;
        exp_t e;
        e.ovf = 0;
        for (int i = 0; i < nt; i++) begin
            x = int'(ops[i][2:0]);
            if (ops[i][3]) x = -x;
            v += x;
            if (v > 7) begin v = 7; e.ovf = 1; end
            if (v < -7) begin v = -7; e.ovf = 1; end
        end
        e.sum = v < 0 ? {1'b1, 3'(-v)} : {1'b0, 3'(v)};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int nt, input ops_t ops, input int gap);
        n_cmp++;
        if (nt > 8) begin n_bad++; $display("FAIL illegal_num_terms got %0d max 8", nt); end
        sb.push_back(model(ops, nt));
        start = 1;
        num_terms = 4'(nt);
        tick();
        start = 0;
        for (int i = 0; i < nt; i++) begin
            if (i > 0) repeat (gap) tick();
            in_valid = 1;
            in_data = ops[i];
            tick();
            in_valid = 0;
            in_data = 4'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) begin
            start = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
            num_terms = 4'($urandom_range(0, 8)); in_data = 4'($urandom);
            tick();
        end
        n_cmp += 5;
        if (in_ready !== 0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        if (out_valid !== 0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (out_sum !== 0) begin n_bad++; $display("FAIL reset_out_sum got %b want 0000", out_sum); end
        if (out_ovf !== 0) begin n_bad++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
        if (busy !== 0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 0; start = 0; in_valid = 0; out_ready = 0;
        tick();
    endtask

    task automatic test_runs(input string name, input int nt, input ops_t ops);
        exp_t e;
        feed(nt, ops, 0);
        e = sb.pop_front();
        n_cmp += 4;
        if (out_valid !== 1) begin n_bad++; $display("FAIL %s_out_valid got %b want 1", name, out_valid); end
        if (out_sum !== e.sum) begin n_bad++; $display("FAIL %s_sum got %b want %b", name, out_sum, e.sum); end
        if (out_ovf !== e.ovf) begin n_bad++; $display("FAIL %s_ovf got %b want %b", name, out_ovf, e.ovf); end
        out_ready = 1;
        tick();
        out_ready = 0;
        if (busy !== 0) begin n_bad++; $display("FAIL %s_idle busy got %b want 0", name, busy); end
    endtask

    task automatic test_basic();
        test_runs("basic", 3, '{4'b0011, 4'b1100, 4'b0110, 0, 0, 0, 0, 0});
    endtask

    task automatic test_saturate();
        test_runs("sat_pos", 2, '{4'b0110, 4'b0110, 0, 0, 0, 0, 0, 0});
        test_runs("sat_neg", 2, '{4'b1110, 4'b1110, 0, 0, 0, 0, 0, 0});
        test_runs("sat_then_sub", 3, '{4'b0110, 4'b0110, 4'b1011, 0, 0, 0, 0, 0});
    endtask

    task automatic test_zero();
        test_runs("cancel", 2, '{4'b0100, 4'b1100, 0, 0, 0, 0, 0, 0});
        test_runs("neg_add", 2, '{4'b1010, 4'b1011, 0, 0, 0, 0, 0, 0});
        test_runs("neg_zero_in", 2, '{4'b1000, 4'b1000, 0, 0, 0, 0, 0, 0});
    endtask

    task automatic test_backpressure();
        exp_t e;
        feed(3, '{4'b0101, 4'b1001, 4'b0011, 0, 0, 0, 0, 0}, 2);
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            start = k == 1;
            num_terms = 2;
            n_cmp += 3;
            if (out_valid !== 1) begin n_bad++; $display("FAIL bp_hold_valid[%0d] got %b want 1", k, out_valid); end
            if (out_sum !== e.sum) begin n_bad++; $display("FAIL bp_hold_sum[%0d] got %b want %b", k, out_sum, e.sum); end
            if (out_ovf !== e.ovf) begin n_bad++; $display("FAIL bp_hold_ovf[%0d] got %b want %b", k, out_ovf, e.ovf); end
            tick();
        end
        out_ready = 1;
        start = 1;
        tick();
        out_ready = 0;
        start = 0;
        n_cmp += 3;
        if (out_valid !== 0) begin n_bad++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        if (busy !== 0) begin n_bad++; $display("FAIL bp_start_ignored busy got %b want 0", busy); end
        if (out_sum !== e.sum) begin n_bad++; $display("FAIL bp_idle_retain got %b want %b", out_sum, e.sum); end
        tick();
    endtask

    task automatic test_empty();
        exp_t e;
        feed(0, '{0, 0, 0, 0, 0, 0, 0, 0}, 0);
        e = sb.pop_front();
        n_cmp += 3;
        if (out_valid !== 1) begin n_bad++; $display("FAIL empty_valid got %b want 1", out_valid); end
        if (out_sum !== e.sum) begin n_bad++; $display("FAIL empty_sum got %b want %b", out_sum, e.sum); end
        if (out_ovf !== e.ovf) begin n_bad++; $display("FAIL empty_ovf got %b want %b", out_ovf, e.ovf); end
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_reset_mid();
        start = 1;
        num_terms = 3;
        tick();
        start = 0;
        in_valid = 1;
        in_data = 4'b0111;
        tick();
        in_valid = 0;
        reset = 1;
        tick();
        reset = 0;
        n_cmp += 4;
        if (in_ready !== 0) begin n_bad++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
        if (busy !== 0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (out_valid !== 0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        if (out_sum !== 0) begin n_bad++; $display("FAIL midrst_sum got %b want 0000", out_sum); end
        test_runs("after_rst", 2, '{4'b0001, 4'b0010, 0, 0, 0, 0, 0, 0});
    endtask

    task automatic test_back_to_back();
        ops_t ops;
        for (int r = 0; r < 6; r++) begin
            foreach (ops[i]) ops[i] = 4'($urandom);
            test_runs("b2b", int'($urandom_range(1, 8)), ops);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_zero();
        test_backpressure();
        test_zero();
        test_empty();
        test_reset_mid();
        test_back_to_back();
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
